ahbl_axi_reset_sequencer: RTL

Downstream consumer of the bridge's synchronised reset. Produces the ordered reset releases for the AXI-side and AHB-side logic of the AHB-Lite-to-AXI bridge. Also runs a drain-then-reset soft-reset sequence.
- Release order: AXI side first, then AHB side after a programmable gap.
- Soft reset: on request, wait for both sides idle, or a timeout, then re-assert both resets.

---
 rtl/ahbl_axi_rst_pkg.sv | 34 +++
 rtl/ahbl_axi_rst_deassert_sync.sv | 31 +++
 rtl/ahbl_axi_reset_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ahbl_axi_rst_pkg.sv
// ahbl_axi_rst_pkg
// Shared definitions for the AHB-Lite-to-AXI bridge reset sequencer:
//   - rst_state_e : sequencer state encoding
//   - min_cnt_w() : smallest counter width able to hold every delay value
//   - cfg_ok()    : configuration legality check used at elaboration
package ahbl_axi_rst_pkg;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_GAP    = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_ASSERT = 3'd4
  } rst_state_e;

  // Width needed to represent the largest of the three delay values.
  function automatic int min_cnt_w(input int axi_hold, input int ahb_delay, input int drain_to);
    int m;
    m = axi_hold;
    if (ahb_delay > m) m = ahb_delay;
    else               m = m;
    if (drain_to > m)  m = drain_to;
    else               m = m;
    return $clog2(m + 1);
  endfunction

  // All delays must be at least one cycle and fit in the counter.
  function automatic bit cfg_ok(input int cnt_w, input int sync_stages, input int axi_hold,
                                input int ahb_delay, input int drain_to);
    return (sync_stages >= 2) && (axi_hold >= 1) && (ahb_delay >= 1) && (drain_to >= 1) &&
           (cnt_w >= min_cnt_w(axi_hold, ahb_delay, drain_to));
  endfunction

endpackage

// File: rtl/ahbl_axi_rst_deassert_sync.sv
// ahbl_axi_rst_deassert_sync
// Asynchronous-assert, synchronous-deassert reset synchroniser.
// Ports:
//   CLK        in  clock
//   RESETINn   in  asynchronous active-low reset
//   sync_rst_n out synchronised reset (0 while in reset, 1 SYNC_STAGES edges after release)
module ahbl_axi_rst_deassert_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESETINn,
  output logic sync_rst_n
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift a constant one into the chain once reset is released.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Synchroniser chain, cleared immediately by the external reset.
  always_ff @(posedge CLK or negedge RESETINn) begin
    if (!RESETINn) sync_q <= {SYNC_STAGES{1'b0}};
    else           sync_q <= sync_d;
  end

  assign sync_rst_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ahbl_axi_reset_sequencer.sv
// ahbl_axi_reset_sequencer
// Ordered reset release for the AXI and AHB sides of the bridge, plus a
// drain-then-reset soft-reset sequence.
// Ports:
//   CLK           in  clock
//   RESETINn      in  asynchronous active-low reset
//   SOFT_RST_REQ  in  soft-reset request, honoured only in RUN
//   AXI_IDLE      in  AXI master has nothing outstanding
//   AHB_IDLE      in  AHB slave has no transfer in progress
//   AXI_RESETn    out active-low reset to AXI-side logic (released first)
//   AHB_RESETn    out active-low reset to AHB-side logic (released AHB_DELAY later)
//   DRAIN_REQ     out ask upstream to stop issuing transfers
//   SEQ_BUSY      out high in every state except RUN
//   TIMEOUT_FLAG  out sticky: last soft reset was forced by the drain timeout
// All outputs are registered; each is updated on the edge that enters the
// state it belongs to.
module ahbl_axi_reset_sequencer
  import ahbl_axi_rst_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int AXI_HOLD      = 16,
  parameter int AHB_DELAY     = 8,
  parameter int DRAIN_TIMEOUT = 255,
  parameter int CNT_W         = 8
) (
  input  logic CLK,
  input  logic RESETINn,
  input  logic SOFT_RST_REQ,
  input  logic AXI_IDLE,
  input  logic AHB_IDLE,
  output logic AXI_RESETn,
  output logic AHB_RESETn,
  output logic DRAIN_REQ,
  output logic SEQ_BUSY,
  output logic TIMEOUT_FLAG
);

  if (!cfg_ok(CNT_W, SYNC_STAGES, AXI_HOLD, AHB_DELAY, DRAIN_TIMEOUT)) begin : g_cfg_err
    $error("ahbl_axi_reset_sequencer: illegal delay/counter configuration");
  end

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] HOLD_TC    = CNT_W'(AXI_HOLD);
  localparam logic [CNT_W-1:0] GAP_TC     = CNT_W'(AHB_DELAY);
  localparam logic [CNT_W-1:0] DRAIN_TC   = CNT_W'(DRAIN_TIMEOUT);

  logic             sync_rst_n;
  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             axi_rstn_q, axi_rstn_d;
  logic             ahb_rstn_q, ahb_rstn_d;
  logic             drain_req_q, drain_req_d;
  logic             busy_q, busy_d;
  logic             tflag_q, tflag_d;

  ahbl_axi_rst_deassert_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK       (CLK),
    .RESETINn  (RESETINn),
    .sync_rst_n(sync_rst_n)
  );

  // Saturating increment; the terminal compare is on the incremented value,
  // so a delay of N ends on the N-th counting edge.
  always_comb begin
    if (cnt_q == CNT_MAX) cnt_inc = cnt_q;
    else                  cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    axi_rstn_d  = axi_rstn_q;
    ahb_rstn_d  = ahb_rstn_q;
    drain_req_d = drain_req_q;
    busy_d      = busy_q;
    tflag_d     = tflag_q;
    case (state_q)
      ST_HOLD: begin
        // Nothing counts until the synchronised release arrives.
        if (!sync_rst_n) begin
          cnt_d = CNT_ZERO;
        end else if (cnt_inc == HOLD_TC) begin
          axi_rstn_d = 1'b1;
          cnt_d      = CNT_ZERO;
          state_d    = ST_GAP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_GAP: begin
        if (cnt_inc == GAP_TC) begin
          ahb_rstn_d = 1'b1;
          busy_d     = 1'b0;
          cnt_d      = CNT_ZERO;
          state_d    = ST_RUN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RUN: begin
        if (SOFT_RST_REQ) begin
          drain_req_d = 1'b1;
          busy_d      = 1'b1;
          tflag_d     = 1'b0;
          cnt_d       = CNT_ZERO;
          state_d     = ST_DRAIN;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      ST_DRAIN: begin
        // Idle is checked before the timeout so a coincident idle wins.
        if (AXI_IDLE && AHB_IDLE) begin
          axi_rstn_d  = 1'b0;
          ahb_rstn_d  = 1'b0;
          drain_req_d = 1'b0;
          cnt_d       = CNT_ZERO;
          state_d     = ST_ASSERT;
        end else if (cnt_inc == DRAIN_TC) begin
          axi_rstn_d  = 1'b0;
          ahb_rstn_d  = 1'b0;
          drain_req_d = 1'b0;
          tflag_d     = 1'b1;
          cnt_d       = CNT_ZERO;
          state_d     = ST_ASSERT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_ASSERT: begin
        // Synchroniser is already released, so HOLD starts counting at once.
        cnt_d   = CNT_ZERO;
        state_d = ST_HOLD;
      end
      default: begin
        axi_rstn_d  = 1'b0;
        ahb_rstn_d  = 1'b0;
        drain_req_d = 1'b0;
        busy_d      = 1'b1;
        cnt_d       = CNT_ZERO;
        state_d     = ST_HOLD;
      end
    endcase
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge CLK or negedge RESETINn) begin
    if (!RESETINn) begin
      state_q     <= ST_HOLD;
      cnt_q       <= CNT_ZERO;
      axi_rstn_q  <= 1'b0;
      ahb_rstn_q  <= 1'b0;
      drain_req_q <= 1'b0;
      busy_q      <= 1'b1;
      tflag_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      axi_rstn_q  <= axi_rstn_d;
      ahb_rstn_q  <= ahb_rstn_d;
      drain_req_q <= drain_req_d;
      busy_q      <= busy_d;
      tflag_q     <= tflag_d;
    end
  end

  assign AXI_RESETn   = axi_rstn_q;
  assign AHB_RESETn   = ahb_rstn_q;
  assign DRAIN_REQ    = drain_req_q;
  assign SEQ_BUSY     = busy_q;
  assign TIMEOUT_FLAG = tflag_q;

endmodule
